// File: rtl/ddio_seq_pkg.sv
// Shared types and constants for the DDIO transmit sequencer.
// Lane patterns are kept wide so they can be sliced down to any lane width up to 64 bits.
package ddio_seq_pkg;

    localparam int STATE_W    = 2;
    localparam int LANE_MAX_W = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_SEND = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    localparam logic [LANE_MAX_W-1:0] PRE_H = {LANE_MAX_W{1'b1}};
    localparam logic [LANE_MAX_W-1:0] PRE_L = {LANE_MAX_W{1'b0}};

endpackage

// File: rtl/ddio_state_reg.sv
// Parameterised-width state register.
// It has an asynchronous active-low reset to the IDLE encoding.
module ddio_state_reg #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // State flop: async reset to the idle encoding, otherwise follow next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ddio_tx_seq.sv
// DDIO transmit sequencer: preamble, len streamed beats, one-cycle tail, done pulse.
// Lane data, oe and done are registered; s_ready and busy decode the registered state.
module ddio_tx_seq
    import ddio_seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 8,
    parameter int PRE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic [2*DATA_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [DATA_W-1:0]   ddio_h,
    output logic [DATA_W-1:0]   ddio_l,
    output logic                ddio_oe,
    output logic                busy,
    output logic                done,
    output logic                err_underrun
);

    localparam int PRE_W = $clog2(PRE_CYC + 1);

    state_t               state_r;
    state_t               state_next_s;
    logic [STATE_W-1:0]   state_q_s;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     beat_cnt_r;
    logic [PRE_W-1:0]     pre_cnt_r;
    logic                 start_ok_s;
    logic                 pre_last_s;
    logic                 beat_acc_s;
    logic                 last_beat_s;

    ddio_state_reg #(
        .W       (STATE_W),
        .RST_VAL (STATE_W'(ST_IDLE))
    ) u_state_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (state_next_s),
        .q     (state_q_s)
    );

    assign state_r     = state_t'(state_q_s);
    assign start_ok_s  = (state_r == ST_IDLE) && start && (len != {LEN_W{1'b0}});
    assign pre_last_s  = (pre_cnt_r == PRE_W'(PRE_CYC - 1));
    assign beat_acc_s  = (state_r == ST_SEND) && s_valid;
    // len_r is never zero once a burst is running, so len_r-1 cannot wrap
    assign last_beat_s = beat_acc_s && (beat_cnt_r == (len_r - LEN_W'(1)));

    assign s_ready = (state_r == ST_SEND);
    assign busy    = (state_r != ST_IDLE);

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_next_s = ST_PRE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (pre_last_s) begin
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_PRE;
                end
            end
            ST_SEND: begin
                if (last_beat_s) begin
                    state_next_s = ST_TAIL;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_TAIL: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Burst bookkeeping: latched length, beat/preamble counters, sticky underrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r        <= {LEN_W{1'b0}};
            beat_cnt_r   <= {LEN_W{1'b0}};
            pre_cnt_r    <= {PRE_W{1'b0}};
            err_underrun <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        len_r        <= len;
                        beat_cnt_r   <= {LEN_W{1'b0}};
                        pre_cnt_r    <= {PRE_W{1'b0}};
                        err_underrun <= 1'b0;
                    end
                end
                ST_PRE: begin
                    pre_cnt_r <= pre_cnt_r + PRE_W'(1);
                end
                ST_SEND: begin
                    if (s_valid) begin
                        beat_cnt_r <= beat_cnt_r + LEN_W'(1);
                    end else begin
                        err_underrun <= 1'b1;
                    end
                end
                ST_TAIL: begin
                    beat_cnt_r <= {LEN_W{1'b0}};
                end
                default: begin
                    beat_cnt_r <= {LEN_W{1'b0}};
                end
            endcase
        end
    end

    // Output register: lane data, output enable and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ddio_h  <= {DATA_W{1'b0}};
            ddio_l  <= {DATA_W{1'b0}};
            ddio_oe <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                ST_PRE: begin
                    ddio_h  <= PRE_H[DATA_W-1:0];
                    ddio_l  <= PRE_L[DATA_W-1:0];
                    ddio_oe <= 1'b1;
                    done    <= 1'b0;
                end
                ST_SEND: begin
                    if (s_valid) begin
                        ddio_h <= s_data[2*DATA_W-1:DATA_W];
                        ddio_l <= s_data[DATA_W-1:0];
                    end else begin
                        ddio_h <= {DATA_W{1'b0}};
                        ddio_l <= {DATA_W{1'b0}};
                    end
                    ddio_oe <= 1'b1;
                    done    <= 1'b0;
                end
                ST_TAIL: begin
                    ddio_h  <= {DATA_W{1'b0}};
                    ddio_l  <= {DATA_W{1'b0}};
                    ddio_oe <= 1'b1;
                    done    <= 1'b1;
                end
                default: begin
                    ddio_h  <= {DATA_W{1'b0}};
                    ddio_l  <= {DATA_W{1'b0}};
                    ddio_oe <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddio_tx_seq.sv
// Randomized self-checking bench for ddio_tx_seq.
// Expected per-edge outputs come from a burst-level trace model built from the valid pattern.
module tb_ddio_tx_seq;

    localparam int DATA_W  = 8;
    localparam int LEN_W   = 8;
    localparam int PRE_CYC = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [LEN_W-1:0]    len;
    logic [2*DATA_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic [DATA_W-1:0]   ddio_h;
    logic [DATA_W-1:0]   ddio_l;
    logic                ddio_oe;
    logic                busy;
    logic                done;
    logic                err_underrun;

    int errors = 0;
    int checks = 0;

    bit                  vld_q[$];
    logic [2*DATA_W-1:0] dat_q[$];

    ddio_tx_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W), .PRE_CYC(PRE_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ddio_h       (ddio_h),
        .ddio_l       (ddio_l),
        .ddio_oe      (ddio_oe),
        .busy         (busy),
        .done         (done),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    // Observed vector: {h, l, oe, done, busy, s_ready, err_underrun}
    function automatic logic [20:0] obs_vec();
        return {ddio_h, ddio_l, ddio_oe, done, busy, s_ready, err_underrun};
    endfunction

    // Plays one burst whose stall pattern is vld_q (one entry per SEND cycle) and beat data dat_q.
    task automatic run_burst(input int blen, input bit noise_start, input bit chain_next,
                             input int next_len, input bit started, input string tag);
        int          sends;
        int          e_done;
        int          bi;
        bit          err_m;
        logic [20:0] expv;
        logic [20:0] obsv;
        sends  = vld_q.size();
        e_done = PRE_CYC + sends + 1;
        bi     = 0;
        err_m  = 1'b0;
        if (!started) begin
            start = 1'b1;
            len   = LEN_W'(blen);
            @(posedge clk); #1;
            checks++;
            expv = {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            if (obs_vec() !== expv) begin
                errors++;
                $display("FAIL %s edge0 got=%h want=%h", tag, obs_vec(), expv);
            end
        end
        for (int e = 1; e <= e_done + 1; e++) begin
            start   = noise_start && (e <= e_done);
            if (noise_start) len = LEN_W'($urandom_range(1, 255));
            if (chain_next && e == e_done + 1) begin
                start = 1'b1;
                len   = LEN_W'(next_len);
            end
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 16'($urandom);
            if (e <= PRE_CYC) begin
                expv = {8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, (e == PRE_CYC), err_m};
            end else if (e <= PRE_CYC + sends) begin
                s_valid = vld_q[e - PRE_CYC - 1];
                if (s_valid) begin
                    s_data = dat_q[bi];
                    bi++;
                end else begin
                    err_m = 1'b1;
                end
                expv = {s_valid ? s_data : 16'h0000, 1'b1, 1'b0, 1'b1,
                        (e < PRE_CYC + sends), err_m};
            end else if (e == e_done) begin
                expv = {8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, err_m};
            end else begin
                expv = {8'h00, 8'h00, 1'b0, 1'b0, chain_next, 1'b0, chain_next ? 1'b0 : err_m};
            end
            @(posedge clk); #1;
            obsv = obs_vec();
            checks++;
            if (obsv !== expv) begin
                errors++;
                $display("FAIL %s edge%0d got=%h want=%h", tag, e, obsv, expv);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
        #12;
        checks++;
        if (obs_vec() !== 21'h0) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs_vec(), 21'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if (obs_vec() !== 21'h0) begin
                errors++;
                $display("FAIL reset_idle got=%h want=%h", obs_vec(), 21'h0);
            end
        end
    endtask

    task automatic test_nominal();
        vld_q = '{1'b1, 1'b1, 1'b1};
        dat_q = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
        run_burst(3, 1'b0, 1'b0, 0, 1'b0, "nominal");
    endtask

    task automatic test_underrun();
        vld_q = '{1'b0, 1'b1, 1'b1};
        dat_q = '{16'($urandom), 16'($urandom)};
        run_burst(2, 1'b0, 1'b0, 0, 1'b0, "underrun");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (err_underrun !== 1'b1) begin
                errors++;
                $display("FAIL underrun_sticky got=%b want=1", err_underrun);
            end
        end
    endtask

    task automatic test_ignored();
        start = 1'b1; len = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, ddio_oe, err_underrun} !== 3'b001) begin
                errors++;
                $display("FAIL len0_ignored got=%b want=001", {busy, ddio_oe, err_underrun});
            end
        end
        start = 1'b0;
        vld_q = '{};
        dat_q = '{};
        for (int i = 0; i < 5; i++) begin
            vld_q.push_back(1'b1);
            dat_q.push_back(16'($urandom));
        end
        run_burst(5, 1'b1, 1'b0, 0, 1'b0, "noise_start");
    endtask

    task automatic test_back_to_back();
        vld_q = '{1'b1, 1'b1};
        dat_q = '{16'h1234, 16'h5678};
        run_burst(2, 1'b0, 1'b1, 3, 1'b0, "b2b_first");
        vld_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        dat_q = '{16'h9ABC, 16'hDEF0, 16'h0F1E};
        run_burst(3, 1'b0, 1'b0, 0, 1'b1, "b2b_second");
    endtask

    task automatic test_reset_mid_send();
        start = 1'b1; len = LEN_W'(4);
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1;
        for (int e = 1; e <= PRE_CYC + 2; e++) begin
            s_data = 16'($urandom);
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 21'h0) begin
            errors++;
            $display("FAIL reset_async got=%h want=%h", obs_vec(), 21'h0);
        end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({done, busy, ddio_oe, s_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_post got=%b want=0000", {done, busy, ddio_oe, s_ready});
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_max_len();
        int got;
        vld_q = '{};
        dat_q = '{};
        got = 0;
        while (got < 255) begin
            if ($urandom_range(0, 99) < 70) begin
                vld_q.push_back(1'b1);
                dat_q.push_back(16'($urandom));
                got++;
            end else begin
                vld_q.push_back(1'b0);
            end
        end
        run_burst(255, 1'b0, 1'b0, 0, 1'b0, "max_len");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_underrun();
        test_ignored();
        test_back_to_back();
        test_reset_mid_send();
        test_max_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
